// File: rtl/enable_gen.sv
// enable_gen: programmable clock-enable generator feeding a counter's en input.
// Divides clk by a run-time divisor and emits single-cycle en_out strobes,
// either continuously (burst 0) or as a finite burst followed by a done pulse.
// Optional build macro: ENABLE_GEN_STATUS_EN adds the strobe_count status port.
module enable_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8,
    parameter int DEFAULT_DIV = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIV_WIDTH-1:0]   div_in,
    input  logic                   load_div,
    input  logic [BURST_WIDTH-1:0] burst_in,
    input  logic                   start,
    input  logic                   stop,
    output logic                   en_out,
    output logic                   busy,
    output logic                   done
`ifdef ENABLE_GEN_STATUS_EN
    ,
    output logic [BURST_WIDTH-1:0] strobe_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [DIV_WIDTH-1:0]   div_reg;
    logic [DIV_WIDTH-1:0]   pre_cnt_reg;
    logic [BURST_WIDTH-1:0] strobe_cnt_reg;
    logic [BURST_WIDTH-1:0] burst_reg;
    logic                   en_out_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic [DIV_WIDTH-1:0]   last_pre_next;
    logic [BURST_WIDTH-1:0] strobe_cnt_next;
    logic                   strobe_due_next;
    logic                   final_strobe_next;

    // Terminal prescale value (a zero divisor behaves as divide-by-one) and
    // whether the strobe due now is the last one of a finite burst.
    always_comb begin
        last_pre_next     = (div_reg == '0) ? '0 : (div_reg - DIV_WIDTH'(1));
        strobe_due_next   = (pre_cnt_reg == last_pre_next);
        strobe_cnt_next   = strobe_cnt_reg + BURST_WIDTH'(1);
        final_strobe_next = (burst_reg != '0) && (strobe_cnt_next == burst_reg);
    end

    // Control FSM with registered outputs; busy deliberately lags the state by one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            div_reg        <= DIV_WIDTH'(DEFAULT_DIV);
            pre_cnt_reg    <= '0;
            strobe_cnt_reg <= '0;
            burst_reg      <= '0;
            en_out_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            busy_reg   <= (state_reg != ST_IDLE);
            en_out_reg <= 1'b0;
            done_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // A coincident load and start both apply, so the run sees the new divisor.
                    if (load_div) begin
                        div_reg <= div_in;
                    end
                    if (start) begin
                        burst_reg      <= burst_in;
                        pre_cnt_reg    <= '0;
                        strobe_cnt_reg <= '0;
                        state_reg      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // stop wins over any strobe (including the final one) due on this edge.
                    if (stop) begin
                        state_reg <= ST_IDLE;
                    end else if (strobe_due_next) begin
                        pre_cnt_reg    <= '0;
                        en_out_reg     <= 1'b1;
                        strobe_cnt_reg <= strobe_cnt_next;
                        if (final_strobe_next) begin
                            state_reg <= ST_DONE;
                        end
                    end else begin
                        pre_cnt_reg <= pre_cnt_reg + DIV_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    // One-cycle completion window; done appears right after the last strobe.
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign en_out = en_out_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

`ifdef ENABLE_GEN_STATUS_EN
    // Strobe counter holds its last value until the next accepted start.
    assign strobe_count = strobe_cnt_reg;
`endif

endmodule

// File: tb/tb_enable_gen.sv
// tb_enable_gen: directed test of enable_gen with an event scoreboard.
// Stimulus pushes the expected (cycle, kind) of every en_out / done pulse;
// the monitor pops and compares whenever the DUT raises either output.
// Define ENABLE_GEN_STATUS_EN to also exercise the strobe_count port.
module tb_enable_gen;

    localparam int DW = 16;
    localparam int BW = 8;
    localparam logic [1:0] EV_EN   = 2'b10;
    localparam logic [1:0] EV_DONE = 2'b01;

    logic          clk;
    logic          rst;
    logic [DW-1:0] div_in;
    logic          load_div;
    logic [BW-1:0] burst_in;
    logic          start;
    logic          stop;
    logic          en_out;
    logic          busy;
    logic          done;
`ifdef ENABLE_GEN_STATUS_EN
    logic [BW-1:0] strobe_count;
`endif

    typedef struct {
        int         cyc;
        logic [1:0] kind;
    } ev_t;

    ev_t exp_q[$];
    int  cyc;
    int  checks;
    int  errors;

    enable_gen #(
        .DIV_WIDTH  (DW),
        .BURST_WIDTH(BW),
        .DEFAULT_DIV(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .div_in      (div_in),
        .load_div    (load_div),
        .burst_in    (burst_in),
        .start       (start),
        .stop        (stop),
        .en_out      (en_out),
        .busy        (busy),
        .done        (done)
`ifdef ENABLE_GEN_STATUS_EN
        ,
        .strobe_count(strobe_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every en_out/done pulse must match the next expected event.
    always @(negedge clk) begin
        if (en_out === 1'b1 || done === 1'b1) begin
            checks = checks + 1;
            $display("[mon] cycle %0d en_out=%b done=%b", cyc, en_out, done);
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL event: got en_out=%b done=%b at cycle %0d, expected no event",
                         en_out, done, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.kind !== {en_out, done}) begin
                    errors = errors + 1;
                    $display("FAIL event: got kind %b at cycle %0d, expected kind %b at cycle %0d",
                             {en_out, done}, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks = checks + 1;
        if (act !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic push_ev(input int c, input logic [1:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Expected pulses of a run whose start was sampled at edge n.
    task automatic push_run(input int n, input int d, input int ns, input bit with_done);
        for (int i = 1; i <= ns; i++) push_ev(n + i * d, EV_EN);
        if (with_done) push_ev(n + ns * d + 1, EV_DONE);
    endtask

    task automatic load(input logic [DW-1:0] v);
        div_in   = v;
        load_div = 1'b1;
        step();
        load_div = 1'b0;
    endtask

    // Drives start for one edge; n returns the number of the sampling edge.
    task automatic do_start(input logic [BW-1:0] b, input bit with_stop, output int n);
        burst_in = b;
        start    = 1'b1;
        stop     = with_stop;
        n        = cyc + 1;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        int n;
        int m;
        int p;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        div_in   = '0;
        load_div = 1'b0;
        burst_in = '0;
        start    = 1'b0;
        stop     = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset_en_out", en_out, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
`ifdef ENABLE_GEN_STATUS_EN
        check("reset_strobe_count", strobe_count, 0);
`endif
        rst = 1'b0;
        step();

        // 1: default divisor 1, continuous; reset mid-run
        do_start(8'd0, 1'b0, n);
        push_run(n, 1, 6, 1'b0);
        check("t1_busy_lags_start", busy, 0);
        step();
        check("t1_busy_high", busy, 1);
        wait_until(n + 6);
        rst = 1'b1;
        step();
        check("t1_rst_en_out", en_out, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_done", done, 0);
        rst = 1'b0;
        step();

        // 2: divisor 4, burst 3
        load(16'd4);
        do_start(8'd3, 1'b0, n);
        push_run(n, 4, 3, 1'b1);
        wait_until(n + 13);
        check("t2_busy_in_done", busy, 1);
        check("t2_done", done, 1);
        step();
        check("t2_busy_after", busy, 0);
        check("t2_done_after", done, 0);
        check("t2_drained", exp_q.size(), 0);

        // 3: divisor 0 acts as 1, burst 2
        load(16'd0);
        do_start(8'd2, 1'b0, n);
        push_run(n, 1, 2, 1'b1);
        wait_until(n + 4);
        check("t3_busy_after", busy, 0);
        check("t3_drained", exp_q.size(), 0);

        // 4a: divisor 5, burst 3, stop on the final strobe edge
        load(16'd5);
        do_start(8'd3, 1'b0, n);
        push_run(n, 5, 2, 1'b0);
        wait_until(n + 14);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4a_stop_en_out", en_out, 0);
        check("t4a_stop_done", done, 0);
        step();
        check("t4a_busy_after", busy, 0);
        check("t4a_done_after", done, 0);
        wait_until(n + 25);
        check("t4a_drained", exp_q.size(), 0);

        // 4b: start together with stop in IDLE, then stop after one strobe
        do_start(8'd3, 1'b1, n);
        push_run(n, 5, 1, 1'b0);
        wait_until(n + 7);
        check("t4b_busy_running", busy, 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_until(n + 30);
        check("t4b_busy_after", busy, 0);
        check("t4b_drained", exp_q.size(), 0);

        // 5: load/start during RUN and start during DONE are ignored
        load(16'd3);
        do_start(8'd2, 1'b0, n);
        push_run(n, 3, 2, 1'b1);
        step();
        div_in   = 16'd7;
        load_div = 1'b1;
        burst_in = 8'd5;
        start    = 1'b1;
        step();
        load_div = 1'b0;
        start    = 1'b0;
        wait_until(n + 6);
        burst_in = 8'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("t5_done_pulse", done, 1);
        do_start(8'd1, 1'b0, m);
        push_run(m, 3, 1, 1'b1);
        wait_until(m + 5);
        check("t5_drained_old_div", exp_q.size(), 0);
        load(16'd7);
        do_start(8'd2, 1'b0, p);
        push_run(p, 7, 2, 1'b1);
        wait_until(p + 16);
        check("t5_drained_new_div", exp_q.size(), 0);

`ifdef ENABLE_GEN_STATUS_EN
        // 6: strobe_count stepping, holding, clearing and wrapping
        load(16'd2);
        do_start(8'd5, 1'b0, n);
        push_run(n, 2, 5, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            wait_until(n + 2 * k);
            check("t6_count_step", strobe_count, k);
        end
        wait_until(n + 11);
        check("t6_count_in_done", strobe_count, 5);
        wait_until(n + 15);
        check("t6_count_in_idle", strobe_count, 5);
        do_start(8'd1, 1'b0, m);
        check("t6_count_cleared", strobe_count, 0);
        push_run(m, 2, 1, 1'b1);
        wait_until(m + 4);
        load(16'd1);
        do_start(8'd0, 1'b0, n);
        push_run(n, 1, 260, 1'b0);
        wait_until(n + 255);
        check("t6_count_255", strobe_count, 255);
        step();
        check("t6_count_wrap0", strobe_count, 0);
        step();
        check("t6_count_wrap1", strobe_count, 1);
        wait_until(n + 260);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t6_count_held_after_stop", strobe_count, 4);
        wait_until(n + 270);
        check("t6_drained", exp_q.size(), 0);
`endif

        repeat (10) step();
        check("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enable_gen.md
Name: enable_gen

Overview:
- Programmable clock-enable generator that sits directly upstream of the counter block and drives its `en` input.
- Divides `clk` by a run-time divisor and emits single-cycle enable strobes.
- Strobes run either continuously or as a finite burst.
- Provides start/stop control and busy/done status so a controller can sequence counter runs.

Parameters:
DIV_WIDTH, 16, width of divisor register and prescale counter
BURST_WIDTH, 8, width of burst length and strobe counter
DEFAULT_DIV, 1, divisor value after reset (0 treated as 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
div_in  input  DIV_WIDTH  divisor value; strobe period in clk cycles
load_div  input  1  loads div_in into divisor register (honoured only in IDLE)
burst_in  input  BURST_WIDTH  strobes per run, captured on start; 0 = continuous
start  input  1  begin a run (honoured only in IDLE)
stop  input  1  abort a run (honoured in RUN)
en_out  output  1  registered enable strobe, connects to the counter's en
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse after the final strobe of a finite burst

Behaviour:
- Reset (rst=1 at a rising edge, any state):
  - state=IDLE; en_out=0, busy=0, done=0.
  - div_q=DEFAULT_DIV; pre_cnt=0, strobe_cnt=0, burst_q=0.
  - Reset overrides all other inputs, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE:
  - load_div=1 → div_q<=div_in next edge.
  - start=1 → burst_q<=burst_in, pre_cnt<=0, strobe_cnt<=0, state<=RUN.
  - load_div and start on the same edge → both take effect; the run uses the new div_in value.
- Effective divisor: d = (div_q==0) ? 1 : div_q.
- RUN prescale:
  - pre_cnt counts 0..d-1 and wraps.
  - en_out is registered high for exactly one cycle each time pre_cnt==d-1, so period = d cycles.
  - First strobe: start sampled at edge N → en_out high from edge N+d to N+d+1.
  - d=1 → en_out high every cycle from edge N+1.
- Strobe counting:
  - Each strobe increments strobe_cnt (BURST_WIDTH bits).
  - burst_q==0 (continuous): no terminal count; strobe_cnt wraps silently modulo 2^BURST_WIDTH.
  - burst_q!=0: on the edge that registers strobe number burst_q, state<=DONE.
  - DONE lasts one cycle: en_out=0, done=1, busy=1; then state<=IDLE.
  - done therefore rises exactly one cycle after the last en_out cycle.
- stop:
  - stop=1 in RUN → state<=IDLE and en_out<=0 on that edge; any strobe due on that edge is suppressed; done stays 0.
  - stop beats a coincident final strobe: no strobe, no done.
  - stop in IDLE or DONE has no effect.
  - stop and start together in IDLE: start honoured (stop is meaningless in IDLE).
- Ignored inputs:
  - start in RUN or DONE is ignored; no restart.
  - load_div outside IDLE is ignored; div_q is stable for the whole run.
- Back-to-back runs: start asserted during the DONE cycle is ignored; the earliest accepted restart is the first IDLE cycle.
- busy: registered and equal to (state!=IDLE); it rises one edge after start is accepted.

Optional Feature:
- Macro: ENABLE_GEN_STATUS_EN.
- Defined:
  - Adds output `strobe_count [BURST_WIDTH-1:0]`, mirroring strobe_cnt.
  - strobe_cnt holds its final value in DONE and IDLE until the next accepted start clears it.
  - Reset value 0.
- Undefined: the port and its driving logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then start with DEFAULT_DIV=1 and burst_in=0 → en_out high every cycle from edge N+1; busy=1; done never asserts. Pulse rst mid-run → en_out=0 and busy=0 on that edge.
2. load_div with div_in=4, then start with burst_in=3 → en_out pulses at N+4, N+8, N+12; done=1 at N+13 only; busy low from N+14.
3. div_in=0 loaded, burst_in=2 → behaves as d=1: strobes at N+1, N+2; done at N+3.
4. div=5, burst=3; assert stop on the edge of the 3rd strobe → no 3rd strobe, done stays 0, busy=0 next cycle. Separately, stop after 1 strobe → return to IDLE with no further strobes.
5. During RUN with div=3: load_div div_in=7 and re-assert start → period stays 3 and run is not restarted. After completion, new start uses 3; after a later IDLE load, period becomes 7.
6. With ENABLE_GEN_STATUS_EN defined, div=2, burst=5 → strobe_count steps 1..5 and holds 5 through DONE and IDLE; next start clears it to 0. With burst=0 run past 256 strobes (BURST_WIDTH=8) → strobe_count wraps 255→0.
